// File: rtl/muldiv_unit_if.sv
// Start/ready request and HI/LO result bundle between the control unit and muldiv_unit.
// The master drives the request; the slave (muldiv_unit) returns results and status.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             ready;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, ready, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, ready, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: shift-add multiply, restoring divide, WIDTH+2 cycles start to ready.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining multiplier bits are all zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_sh_q, mcand_sh_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH:0]      rem_q, rem_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                div_zero_q, div_zero_d;

  logic                is_div;
  logic                is_signed;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [2*WIDTH-1:0]  mul_add;
  logic [WIDTH+1:0]    div_shift;
  logic [WIDTH+1:0]    div_diff;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_fix;
  logic [WIDTH-1:0]    rem_fix;
  logic                mul_done;
  logic                run_last;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  assign mul_add   = mplier_q[0] ? mcand_sh_q : '0;
  // Restoring step: shift the next dividend bit into the partial remainder, trial-subtract the divisor.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, mcand_sh_q[WIDTH-1:0]};

  assign prod_fix  = neg_q  ? -acc_q : acc_q;
  assign quo_fix   = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_done  = (mplier_q[WIDTH-1:1] == '0);
`else
  assign mul_done  = 1'b0;
`endif
  assign run_last  = (cnt_q == CW'(1)) || (!is_div && mul_done);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_sh_d = mcand_sh_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d       = bus.op;
          a_d        = bus.a;
          b_d        = bus.b;
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_PREP;
        end
      end
      S_PREP: begin
        neg_d  = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d = is_signed & a_q[WIDTH-1];
        cnt_d  = CW'(WIDTH);
        dz_d   = is_div && (b_q == '0);
        rem_d  = '0;
        if (is_div) begin
          acc_d      = {{WIDTH{1'b0}}, a_mag};
          mcand_sh_d = {{WIDTH{1'b0}}, b_mag};
          mplier_d   = '0;
        end else begin
          acc_d      = '0;
          mcand_sh_d = {{WIDTH{1'b0}}, a_mag};
          mplier_d   = b_mag;
        end
        // A zero divisor skips the datapath; FIX then only raises the flag.
        state_d = (is_div && (b_q == '0)) ? S_FIX : S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div) begin
          if (div_diff[WIDTH+1]) begin
            rem_d = div_shift[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = div_diff[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_d      = acc_q + mul_add;
          mcand_sh_d = mcand_sh_q << 1;
          mplier_d   = mplier_q >> 1;
        end
        if (run_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_sh_q <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_sh_q <= mcand_sh_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table for muldiv_unit at WIDTH=32, plus hand sequences for start-while-busy and mid-run reset.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_B3 = 4;
  localparam int LAT_B0 = 3;
`else
  localparam int LAT_B3 = 34;
  localparam int LAT_B0 = 34;
`endif

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;
  vec_t vecs[10];

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following the ready cycle.
  task automatic run_op(input vec_t v);
    int cyc;
    cyc = 0;
    bus.start = 1'b1;
    bus.op = v.op;
    bus.a = v.a;
    bus.b = v.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({v.name, " busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
    chk({v.name, " dz_cleared_on_accept"}, {31'd0, bus.div_zero}, 32'd0);
    while (!bus.ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({v.name, " hi"}, bus.hi, v.exp_hi);
    chk({v.name, " lo"}, bus.lo, v.exp_lo);
    chk({v.name, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, v.exp_dz});
    chk({v.name, " busy_in_ready"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk({v.name, " ready_single"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    passed = 0;
    total = 0;
    vecs[0] = '{"mult_neg3x7",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[1] = '{"multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[2] = '{"mult_m1xm1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[3] = '{"div_neg7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[4] = '{"div_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[5] = '{"divu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[6] = '{"divu_by_zero",  2'b11, 32'd100,      32'd0,        32'd2,        32'd14,       1'b1, 2};
    vecs[7] = '{"multu_5x3",     2'b01, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0, LAT_B3};
    vecs[8] = '{"multu_by_zero", 2'b01, 32'h00001234, 32'd0,        32'd0,        32'd0,        1'b0, LAT_B0};
    vecs[9] = '{"div_7_neg2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};

    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset ready", {31'd0, bus.ready}, 32'd0);
    chk("reset div_zero", {31'd0, bus.div_zero}, 32'd0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // A second start during RUN must be ignored, including its zero divisor.
    cyc = 0;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'h10;
    bus.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.op = 2'b11;
    bus.a = 32'd9;
    bus.b = 32'd0;
    bus.start = 1'b0;
    while (!bus.ready && cyc < 100) begin
      bus.start = (cyc == 4);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("busy_start latency", 32'(cyc), 32'd34);
    chk("busy_start hi", bus.hi, 32'h0000000F);
    chk("busy_start lo", bus.lo, 32'hFFFFFFF0);
    chk("busy_start div_zero", {31'd0, bus.div_zero}, 32'd0);
    @(posedge clk); #1;
    chk("busy_start no_second_op", {31'd0, bus.busy}, 32'd0);

    // Reset mid-RUN clears outputs at once and no result follows.
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd5;
    bus.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("midreset busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset hi", bus.hi, 32'd0);
    chk("midreset lo", bus.lo, 32'd0);
    chk("midreset ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready || bus.busy) seen++;
    end
    chk("midreset no_ready_after", 32'(seen), 32'd0);
    chk("midreset lo_held", bus.lo, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
